// File: rtl/sdram_arbiter_if.sv
// Requester and SDRAM-controller bus bundle for sdram_arbiter; slave = arbiter view, master = driver/responder view.
// Requester fields are packed per port: addr[i*ADDR_W +: ADDR_W], din[i*16 +: 16], ds[i*2 +: 2].
interface sdram_arbiter_if #(
    parameter int ADDR_W = 22
);
    logic [2:0]          req;
    logic [2:0]          we;
    logic [3*ADDR_W-1:0] addr;
    logic [47:0]         din;
    logic [5:0]          ds;
    logic [2:0]          ack;
    logic [15:0]         dout;
    logic                mem_start;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [15:0]         mem_din;
    logic [1:0]          mem_ds;
    logic                mem_ready;
    logic [15:0]         mem_dout;

    modport slave (
        input  req, we, addr, din, ds, mem_ready, mem_dout,
        output ack, dout, mem_start, mem_we, mem_addr, mem_din, mem_ds
    );

    modport master (
        output req, we, addr, din, ds, mem_ready, mem_dout,
        input  ack, dout, mem_start, mem_we, mem_addr, mem_din, mem_ds
    );
endinterface

// File: rtl/sdram_arbiter.sv
// 3-port SDRAM access sequencer, CPU > ARAM > RV with RV anti-starvation (RV port only with SDRAM_ARBITER_RV_EN).
// Request-to-ack 4 cycles minimum; no backpressure: a req to an already pending port is dropped and flagged in overrun.
module sdram_arbiter #(
    parameter int ADDR_W        = 22,
    parameter int RV_STARVE_MAX = 8
) (
    input  logic                i_clk,
    input  logic                i_reset,
    sdram_arbiter_if.slave      if_bus,
    output logic                o_rv_wait,
    output logic [2:0]          o_overrun,
    output logic                o_busy
);
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

`ifdef SDRAM_ARBITER_RV_EN
    localparam logic [2:0] PORT_EN = 3'b111;
`else
    localparam logic [2:0] PORT_EN = 3'b011;
`endif

    state_t              r_state;
    state_t              w_next;
    logic [2:0]          r_pend;
    logic [2:0]          r_overrun;
    logic [2:0]          r_we;
    logic [ADDR_W-1:0]   r_addr [3];
    logic [15:0]         r_din  [3];
    logic [1:0]          r_ds   [3];
    logic [1:0]          r_win;
    logic [7:0]          r_starve;
    logic [15:0]         r_dout;
    logic                r_mem_we;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [15:0]         r_mem_din;
    logic [1:0]          r_mem_ds;
    logic [2:0]          w_req;
    logic [2:0]          w_clr;
    logic [1:0]          w_sel;
    logic                w_any;
    logic                w_grant;

    assign w_req   = if_bus.req & PORT_EN;
    assign w_any   = |r_pend;
    assign w_grant = (r_state == S_IDLE) && w_any;
    assign w_clr   = (r_state == S_DONE) ? (3'b001 << r_win) : 3'b000;

    always_comb begin
        w_sel = 2'd0;
        if (r_pend[2] && (r_starve == 8'(RV_STARVE_MAX)))
            w_sel = 2'd2;
        else if (r_pend[0])
            w_sel = 2'd0;
        else if (r_pend[1])
            w_sel = 2'd1;
        else if (r_pend[2])
            w_sel = 2'd2;
    end

    // A winner re-requesting in its DONE cycle is re-armed, not counted as overrun.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_pend    <= 3'b000;
            r_overrun <= 3'b000;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (w_req[i]) begin
                    if (!r_pend[i] || w_clr[i]) begin
                        r_pend[i] <= 1'b1;
                        r_we[i]   <= if_bus.we[i];
                        r_addr[i] <= if_bus.addr[i*ADDR_W +: ADDR_W];
                        r_din[i]  <= if_bus.din[i*16 +: 16];
                        r_ds[i]   <= if_bus.ds[i*2 +: 2];
                    end else begin
                        r_overrun[i] <= 1'b1;
                    end
                end else if (w_clr[i]) begin
                    r_pend[i] <= 1'b0;
                end
            end
        end
    end

`ifdef SDRAM_ARBITER_RV_EN
    always_ff @(posedge i_clk) begin
        if (i_reset || !r_pend[2])
            r_starve <= 8'd0;
        else if (w_grant) begin
            if (w_sel == 2'd2)
                r_starve <= 8'd0;
            else if (r_starve != 8'hff)
                r_starve <= r_starve + 8'd1;
        end
    end
`else
    always_ff @(posedge i_clk) begin
        r_starve <= 8'd0;
    end
`endif

    always_ff @(posedge i_clk) begin
        if (i_reset)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_any) w_next = S_ISSUE;
            S_ISSUE: w_next = S_WAIT;
            S_WAIT:  if (if_bus.mem_ready) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_win      <= 2'd0;
            r_mem_we   <= 1'b0;
            r_mem_addr <= '0;
            r_mem_din  <= 16'd0;
            r_mem_ds   <= 2'd0;
            r_dout     <= 16'd0;
        end else begin
            if (w_grant) begin
                r_win      <= w_sel;
                r_mem_we   <= r_we[w_sel];
                r_mem_addr <= r_addr[w_sel];
                r_mem_din  <= r_din[w_sel];
                r_mem_ds   <= r_ds[w_sel];
            end
            if ((r_state == S_WAIT) && if_bus.mem_ready && !r_mem_we)
                r_dout <= if_bus.mem_dout;
        end
    end

    always_comb begin
        if_bus.mem_start = (r_state == S_ISSUE);
        if_bus.ack       = w_clr;
        o_busy           = (r_state != S_IDLE);
        o_rv_wait        = r_pend[2] && !w_clr[2];
    end

    assign if_bus.dout     = r_dout;
    assign if_bus.mem_we   = r_mem_we;
    assign if_bus.mem_addr = r_mem_addr;
    assign if_bus.mem_din  = r_mem_din;
    assign if_bus.mem_ds   = r_mem_ds;
    assign o_overrun       = r_overrun;
endmodule
